// File: rtl/dram_pad_bscan_seq.sv
// ---------------------------------------------------------------------------
// dram_pad_bscan_seq
//
// Boundary-scan sequencer for a chain of DRAM DQ pads. It generates the
// capture / shift / update strobes for the pad scan chain. It shifts a
// parallel write vector into the chain MSB first. It also collects the bits
// returned on bso into a parallel read vector.
//
// Ports
//   clk, rst           sequencer clock, asynchronous active-high reset
//   i_start            operation request, honoured only while o_busy is low
//   i_do_capture       run the capture phase (sampled with i_start)
//   i_do_update        run the update phase (sampled with i_start)
//   i_mode_req         value for o_mode_ctrl (sampled with i_start)
//   i_wr_data          parallel vector, bit i ends up in chain cell i
//   i_bso              serial output of the last chain cell
//   o_shift_dr         1 = shift, 0 = capture
//   o_clock_dr         scan-cell clock strobe
//   o_update_dr        update-latch strobe
//   o_mode_ctrl        pad drive-source select
//   o_bsi              serial input to chain cell 0
//   o_busy             operation in progress
//   o_done             one-cycle completion pulse
//   o_rd_data          chain contents read back, bit i from cell i
// ---------------------------------------------------------------------------
module dram_pad_bscan_seq #(
  parameter int CHAIN_LEN = 72,
  parameter int CNT_W     = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic                 i_do_capture,
  input  logic                 i_do_update,
  input  logic                 i_mode_req,
  input  logic [CHAIN_LEN-1:0] i_wr_data,
  input  logic                 i_bso,
  output logic                 o_shift_dr,
  output logic                 o_clock_dr,
  output logic                 o_update_dr,
  output logic                 o_mode_ctrl,
  output logic                 o_bsi,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [CHAIN_LEN-1:0] o_rd_data
);

  typedef enum logic [2:0] {
    IDLE,
    CAP_S,
    CAP_P,
    SH_S,
    SH_P,
    UPD_S,
    UPD_P,
    DONE
  } state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic [CHAIN_LEN-1:0] r_sreg;
  logic [CHAIN_LEN-1:0] w_sregNext;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cntNext;
  logic                 r_bsoQ;
  logic                 r_doUpdate;
  logic                 r_shiftDr;
  logic                 r_clockDr;
  logic                 r_updateDr;
  logic                 r_modeCtrl;
  logic                 r_bsi;
  logic                 r_busy;
  logic                 r_done;
  logic [CHAIN_LEN-1:0] r_rdData;
  logic                 w_accept;
  logic                 w_lastBit;
  logic                 w_shiftNext;
  logic                 w_clockNext;
  logic                 w_updateNext;
  logic                 w_bsiNext;

  assign w_accept  = (r_state == IDLE) && i_start;
  assign w_lastBit = (r_cnt == CNT_W'(CHAIN_LEN - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. DONE always returns to IDLE, so a start that is
  // presented during DONE is ignored and only honoured one cycle later.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_nextState = i_do_capture ? CAP_S : SH_S;
        end
      end
      CAP_S: w_nextState = CAP_P;
      CAP_P: w_nextState = SH_S;
      SH_S:  w_nextState = SH_P;
      SH_P: begin
        if (w_lastBit) begin
          w_nextState = r_doUpdate ? UPD_S : DONE;
        end else begin
          w_nextState = SH_S;
        end
      end
      UPD_S:   w_nextState = UPD_P;
      UPD_P:   w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Shift register and bit counter next values. The bit returned by the
  // chain enters at the LSB, so after CHAIN_LEN shifts the vector
  // lines up with the chain cell numbering.
  always_comb begin
    w_sregNext = r_sreg;
    w_cntNext  = r_cnt;
    if (w_accept) begin
      w_sregNext = i_wr_data;
      w_cntNext  = '0;
    end else if (r_state == SH_P) begin
      w_sregNext = {r_sreg[CHAIN_LEN-2:0], r_bsoQ};
      w_cntNext  = w_lastBit ? '0 : r_cnt + 1'b1;
    end
  end

  // Output values are decoded from the state being entered. Registering
  // them makes every output a flop while keeping it aligned with the state.
  // bsi is taken from the next shift-register value, so it already shows
  // the following bit in the cycle after a shift.
  always_comb begin
    w_shiftNext  = (w_nextState == SH_S) || (w_nextState == SH_P);
    w_clockNext  = (w_nextState == CAP_P) || (w_nextState == SH_P);
    w_updateNext = (w_nextState == UPD_P);
    w_bsiNext    = w_shiftNext ? w_sregNext[CHAIN_LEN-1] : 1'b0;
  end

  // Datapath and output registers. The read vector loads only on entry to
  // DONE, so an operation cut short by reset never exposes a partial shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sreg     <= '0;
      r_cnt      <= '0;
      r_bsoQ     <= 1'b0;
      r_doUpdate <= 1'b0;
      r_shiftDr  <= 1'b0;
      r_clockDr  <= 1'b0;
      r_updateDr <= 1'b0;
      r_modeCtrl <= 1'b0;
      r_bsi      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rdData   <= '0;
    end else begin
      r_sreg     <= w_sregNext;
      r_cnt      <= w_cntNext;
      r_shiftDr  <= w_shiftNext;
      r_clockDr  <= w_clockNext;
      r_updateDr <= w_updateNext;
      r_bsi      <= w_bsiNext;
      r_busy     <= (w_nextState != IDLE);
      r_done     <= (w_nextState == DONE);
      if (r_state == SH_S) begin
        r_bsoQ <= i_bso;
      end
      if (w_accept) begin
        r_doUpdate <= i_do_update;
        r_modeCtrl <= i_mode_req;
      end
      if (w_nextState == DONE) begin
        r_rdData <= w_sregNext;
      end
    end
  end

  assign o_shift_dr  = r_shiftDr;
  assign o_clock_dr  = r_clockDr;
  assign o_update_dr = r_updateDr;
  assign o_mode_ctrl = r_modeCtrl;
  assign o_bsi       = r_bsi;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_rd_data   = r_rdData;

endmodule

// File: tb/tb_dram_pad_bscan_seq.sv
// ---------------------------------------------------------------------------
// tb_dram_pad_bscan_seq
//
// Bench for dram_pad_bscan_seq with an 8-cell chain. A pad-row model
// captures, shifts and latches on the DUT strobes. An operation-level model
// predicts every output from the cycle offset within the operation.
// ---------------------------------------------------------------------------
module tb_dram_pad_bscan_seq;

  localparam int N  = 8;
  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         doCapture;
  logic         doUpdate;
  logic         modeReq;
  logic [N-1:0] wrData;
  logic         bso;
  logic         shiftDr;
  logic         clockDr;
  logic         updateDr;
  logic         modeCtrl;
  logic         bsi;
  logic         busy;
  logic         done;
  logic [N-1:0] rdData;

  int assertCount = 0;
  int failCount   = 0;
  int cycNum      = 0;

  dram_pad_bscan_seq #(.CHAIN_LEN(N), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (start),
    .i_do_capture(doCapture),
    .i_do_update (doUpdate),
    .i_mode_req  (modeReq),
    .i_wr_data   (wrData),
    .i_bso       (bso),
    .o_shift_dr  (shiftDr),
    .o_clock_dr  (clockDr),
    .o_update_dr (updateDr),
    .o_mode_ctrl (modeCtrl),
    .o_bsi       (bsi),
    .o_busy      (busy),
    .o_done      (done),
    .o_rd_data   (rdData)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycNum++;

  // Pad row: cell 0 is fed from bsi, the last cell drives bso.
  logic [N-1:0] padVal = '0;
  logic [N-1:0] cells  = '0;
  logic [N-1:0] latchQ = '0;
  int clockPulses  = 0;
  int updatePulses = 0;

  assign bso = cells[N-1];

  always @(posedge clk) begin
    if (clockDr) begin
      clockPulses++;
      if (shiftDr) cells <= {cells[N-2:0], bsi};
      else         cells <= padVal;
    end
    if (updateDr) begin
      updatePulses++;
      latchQ <= cells;
    end
  end

  // Operation model: tracks the cycle offset inside the current operation.
  logic         mActive = 1'b0;
  int           mK      = 0;
  int           mTotal  = 0;
  logic         mCap    = 1'b0;
  logic         mUpd    = 1'b0;
  logic [N-1:0] mWr     = '0;
  logic [N-1:0] mBefore = '0;
  logic [N-1:0] rdExp   = '0;
  logic         modeExp = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mActive = 1'b0;
      mK      = 0;
      rdExp   = '0;
      modeExp = 1'b0;
    end else if (mActive) begin
      if (mK == mTotal) begin
        mActive = 1'b0;
      end else begin
        mK++;
        if (mK == mTotal) rdExp = mCap ? padVal : mBefore;
      end
    end else if (start) begin
      mActive = 1'b1;
      mK      = 1;
      mCap    = doCapture;
      mUpd    = doUpdate;
      mWr     = wrData;
      mBefore = cells;
      modeExp = modeReq;
      mTotal  = (doCapture ? 2 : 0) + 2 * N + (doUpdate ? 2 : 0) + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [N-1:0] act,
                             input logic [N-1:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cycNum);
    end
  endtask

  // Every-cycle comparison of all outputs against the operation model.
  logic eShift, eClock, eUpd, eBsi, eBusy, eDone;
  int   k, s0, s1, c2;
  always @(negedge clk) begin
    eShift = 1'b0; eClock = 1'b0; eUpd = 1'b0;
    eBsi   = 1'b0; eBusy  = 1'b0; eDone = 1'b0;
    if (mActive) begin
      k      = mK;
      c2     = mCap ? 2 : 0;
      s0     = c2 + 1;
      s1     = c2 + 2 * N;
      eBusy  = 1'b1;
      eDone  = (k == mTotal);
      eShift = (k >= s0) && (k <= s1);
      eClock = (mCap && k == 2) || (eShift && ((k - s0) % 2 == 1));
      eUpd   = mUpd && (k == s1 + 2);
      eBsi   = eShift ? mWr[N-1-(k-s0)/2] : 1'b0;
    end
    checkOutput("shift_dr", N'(shiftDr), N'(eShift));
    checkOutput("clock_dr", N'(clockDr), N'(eClock));
    checkOutput("update_dr", N'(updateDr), N'(eUpd));
    checkOutput("bsi", N'(bsi), N'(eBsi));
    checkOutput("busy", N'(busy), N'(eBusy));
    checkOutput("done", N'(done), N'(eDone));
    checkOutput("mode_ctrl", N'(modeCtrl), N'(modeExp));
    checkOutput("rd_data", rdData, rdExp);
  end

  // Launch one operation and return the cycle offset of done.
  task automatic applyStimulus(input logic cap, input logic upd, input logic mode,
                               input logic [N-1:0] wr, input logic holdStart,
                               output int doneAt);
    int s;
    @(negedge clk);
    doCapture = cap;
    doUpdate  = upd;
    modeReq   = mode;
    wrData    = wr;
    start     = 1'b1;
    s         = cycNum;
    doneAt    = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!holdStart) start = 1'b0;
      if (done) begin
        doneAt = cycNum - s;
        break;
      end
    end
    if (doneAt < 0) checkOutput("done_timeout", 8'd0, 8'd1);
  endtask

  int           d;
  logic [N-1:0] savedLatch;

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    doCapture = 1'b0;
    doUpdate  = 1'b0;
    modeReq   = 1'b0;
    wrData    = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", N'(busy), 8'd0);
    checkOutput("reset_rd", rdData, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // Full operation: capture and update.
    padVal = 8'hA5; clockPulses = 0; updatePulses = 0;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, d);
    checkOutput("full_done_cycle", N'(d), 8'd21);
    checkOutput("full_rd", rdData, 8'hA5);
    @(negedge clk);
    checkOutput("full_latch", latchQ, 8'h3C);
    checkOutput("full_clock_pulses", N'(clockPulses), 8'd9);
    checkOutput("full_update_pulses", N'(updatePulses), 8'd1);

    // Shift only: returns what the previous operation left in the chain.
    clockPulses = 0; updatePulses = 0;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, d);
    checkOutput("shift_done_cycle", N'(d), 8'd17);
    checkOutput("shift_rd", rdData, 8'h3C);
    @(negedge clk);
    checkOutput("shift_update_pulses", N'(updatePulses), 8'd0);
    checkOutput("shift_clock_pulses", N'(clockPulses), 8'd8);

    // start held high: one operation, the next begins two cycles after done.
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h81, 1'b1, d);
    checkOutput("held_done_cycle", N'(d), 8'd21);
    @(negedge clk);
    checkOutput("held_idle_gap", N'(busy), 8'd0);
    @(negedge clk);
    checkOutput("held_restart", N'(busy), 8'd1);
    start = 1'b0;
    d = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        d = i;
        break;
      end
    end
    checkOutput("held_second_done", N'(d >= 0), 8'd1);
    checkOutput("held_second_rd", rdData, 8'hA5);
    @(negedge clk);

    // Reset in cycle 10 of a full operation.
    savedLatch = latchQ;
    doCapture = 1'b1; doUpdate = 1'b1; modeReq = 1'b1; wrData = 8'h99;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_async_outputs",
                {shiftDr, clockDr, updateDr, modeCtrl, bsi, busy, done, 1'b0}, 8'h00);
    checkOutput("rst_async_rd", rdData, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_latch_kept", latchQ, savedLatch);
    padVal = 8'h5A;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h66, 1'b0, d);
    checkOutput("after_rst_done_cycle", N'(d), 8'd21);
    checkOutput("after_rst_rd", rdData, 8'h5A);
    @(negedge clk);
    checkOutput("after_rst_latch", latchQ, 8'h66);

    // mode_ctrl follows mode_req and holds after done.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h0F, 1'b0, d);
    checkOutput("mode_done_cycle", N'(d), 8'd19);
    @(negedge clk);
    checkOutput("mode_held", N'(modeCtrl), 8'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'hF0, 1'b0, d);
    checkOutput("mode_rd", rdData, 8'h0F);
    @(negedge clk);
    checkOutput("mode_cleared", N'(modeCtrl), 8'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/dram_pad_bscan_seq.md
# dram_pad_bscan_seq

Boundary-scan sequencer that drives the JTAG side of a chain of DRAM DQ pads. It produces the capture, shift and update strobes that the pad chain consumes (`shift_dr`, `clock_dr`, `update_dr`, `mode_ctrl`, `bsi`). It shifts a parallel write vector into the chain and returns the captured pad values read back through `bso`. It sits between the test/JTAG controller and the DQ pad row.

## Interface
- CHAIN_LEN, 72: number of scan cells in the chain, one per DQ pad; must be ≥ 2.
- CNT_W, 7: bit-counter width; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- clk  in  1  sequencer clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request pulse; accepted only when `busy`=0.
- do_capture  in  1  sampled with `start`: run the capture phase.
- do_update  in  1  sampled with `start`: run the update phase.
- mode_req  in  1  sampled with `start`: value driven on `mode_ctrl` for the operation.
- wr_data  in  CHAIN_LEN  sampled with `start`: bit i is loaded into chain cell i.
- bso  in  1  serial output of the last chain cell (cell CHAIN_LEN-1).
- shift_dr  out  1  to pads; 1 = shift, 0 = capture.
- clock_dr  out  1  to pads; scan-cell clock strobe.
- update_dr  out  1  to pads; update-latch strobe.
- mode_ctrl  out  1  to pads; selects boundary-scan data as the pad drive source.
- bsi  out  1  serial input to chain cell 0.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- rd_data  out  CHAIN_LEN  captured chain contents; bit i comes from cell i.

## Operation
- Chain topology: bsi → cell0 → … → cell(CHAIN_LEN-1) → bso.
- Internal shift register `sreg` is loaded with `wr_data` on an accepted `start`.
- Shift order is MSB first:
  - bsi = sreg[CHAIN_LEN-1].
  - After each bit, sreg ← {sreg[CHAIN_LEN-2:0], bso_q}.
- FSM states: IDLE, CAP_S, CAP_P, SH_S, SH_P, UPD_S, UPD_P, DONE.
  - IDLE –start→ CAP_S if do_capture, else SH_S.
  - CAP_S: shift_dr=0. Next state CAP_P.
  - CAP_P: clock_dr=1, shift_dr=0. Next state SH_S.
  - SH_S: shift_dr=1, bsi valid; bso is registered into bso_q at the end of this cycle. Next state SH_P.
  - SH_P: clock_dr=1, shift_dr=1, bsi held. sreg shifts at the end of this cycle and the bit counter increments. After CHAIN_LEN bits, go to UPD_S if do_update, else DONE; otherwise go to SH_S.
  - UPD_S: shift_dr=0. Next state UPD_P.
  - UPD_P: update_dr=1. Next state DONE.
  - DONE: done=1, rd_data ← sreg. Next state IDLE.
- `mode_ctrl` takes `mode_req` on an accepted start and holds it after DONE until the next accepted start.
- `rd_data` updates only in DONE.
  - Without capture, it returns the chain's prior shift contents.
- All outputs are registered; no combinational path from any input to any output.

## Timing
- Reset values: shift_dr, clock_dr, update_dr, mode_ctrl, bsi, busy, done = 0; rd_data = 0; state IDLE; counter 0.
- Cycle numbering: start is high in cycle 0.
  - Full operation (capture and update): CAP_S in cycle 1, shift in cycles 3 .. 2N+2, UPD_P in cycle 2N+4, done in cycle 2N+5.
  - Omitting capture: subtract 2 cycles.
  - Omitting update: subtract 2 cycles.
- busy is 1 from cycle 1 through the DONE cycle inclusive.
- start is ignored while busy=1, including in the DONE cycle. A start in the first IDLE cycle after DONE is accepted.
- clock_dr and update_dr are always single-cycle pulses and never coincide.
- shift_dr is stable for the setup cycle before and during every clock_dr pulse.
- When rst asserts mid-operation, all outputs clear immediately (asynchronously) and no further clock_dr or update_dr is issued. A partial shift is discarded and rd_data is 0.

## Test plan
- Reset: assert rst at any time → all outputs 0, busy 0, even mid-shift.
- Full operation, CHAIN_LEN=8, chain model with capture value 0xA5, wr_data=0x3C, capture=update=1:
  - rd_data=0xA5.
  - Model update latch = 0x3C.
  - Exactly 9 clock_dr pulses and 1 update_dr pulse.
  - done in cycle 21.
- Shift-only (capture=update=0) after the previous test, wr_data=0xFF:
  - rd_data=0x3C.
  - No update_dr pulse.
  - done in cycle 17.
- start held high continuously through an operation: exactly one operation runs; a second starts in the cycle after DONE+1.
- rst pulsed at cycle 10 of a full operation → outputs 0 immediately, the model update latch is unchanged, and a subsequent operation completes correctly.
- mode_req=1 with start → mode_ctrl=1 from cycle 1 and holds after done; next start with mode_req=0 → mode_ctrl=0.
